// File: rtl/alu_pkg.sv
// Shared opcode and status-flag constants for the add/sub datapath.
package alu_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int FLG_C = 0;
  localparam int FLG_V = 1;
  localparam int FLG_Z = 2;
  localparam int FLG_N = 3;
  localparam int FLG_W = 4;
endpackage

// File: rtl/add_sub_slice.sv
// Combinational W-bit adder slice: {cout, s} = a + b + cin.
module add_sub_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/add_sub_pipe.sv
// Two-stage pipelined add/subtract with valid/ready handshake and C/V/Z/N flags.
// Define ADD_SUB_SAT_EN to clamp overflowing results to the signed max/min.
module add_sub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  localparam int LO_W = WIDTH / 2;
  localparam int HI_W = WIDTH - LO_W;

  // The operation is fully encoded in bp_hi_reg and lo_carry_reg, so stage 2 needs no opcode.
  logic             s1_valid_reg;
  logic [HI_W-1:0]  a_hi_reg;
  logic [HI_W-1:0]  bp_hi_reg;
  logic [LO_W-1:0]  lo_sum_reg;
  logic             lo_carry_reg;

  logic             s2_valid_reg;
  logic [WIDTH-1:0] sum_reg;
  logic [FLG_W-1:0] flags_reg;

  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic             cin;
  logic [WIDTH-1:0] bp;
  logic [LO_W-1:0]  lo_sum_next;
  logic             lo_carry_next;
  logic [HI_W-1:0]  hi_sum;
  logic             hi_carry;
  logic [WIDTH-1:0] raw_sum;
  logic             ovf_next;
  logic [WIDTH-1:0] sum_next;
  logic [FLG_W-1:0] flags_next;

  assign s2_adv   = !s2_valid_reg || out_ready;
  assign s1_adv   = s2_adv || !s1_valid_reg;
  assign in_ready = !rst && s1_adv;
  assign accept   = in_valid && in_ready;

  assign cin = (sel == OP_SUB);
  assign bp  = cin ? ~in1 : in1;

  add_sub_slice #(.W(LO_W)) u_lo (
    .a    (in0[LO_W-1:0]),
    .b    (bp[LO_W-1:0]),
    .cin  (cin),
    .s    (lo_sum_next),
    .cout (lo_carry_next)
  );

  add_sub_slice #(.W(HI_W)) u_hi (
    .a    (a_hi_reg),
    .b    (bp_hi_reg),
    .cin  (lo_carry_reg),
    .s    (hi_sum),
    .cout (hi_carry)
  );

  assign raw_sum  = {hi_sum, lo_sum_reg};
  assign ovf_next = (a_hi_reg[HI_W-1] == bp_hi_reg[HI_W-1]) &&
                    (raw_sum[WIDTH-1] != a_hi_reg[HI_W-1]);

  always_comb begin
    sum_next = raw_sum;
`ifdef ADD_SUB_SAT_EN
    // Overflow direction follows the sign of A: positive overflow -> max, negative -> min.
    if (ovf_next) begin
      sum_next = a_hi_reg[HI_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
    flags_next        = '0;
    flags_next[FLG_C] = hi_carry;
    flags_next[FLG_V] = ovf_next;
    flags_next[FLG_Z] = (sum_next == '0);
    flags_next[FLG_N] = sum_next[WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      a_hi_reg     <= '0;
      bp_hi_reg    <= '0;
      lo_sum_reg   <= '0;
      lo_carry_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      sum_reg      <= '0;
      flags_reg    <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid_reg <= accept;
      end
      if (accept) begin
        a_hi_reg     <= in0[WIDTH-1:LO_W];
        bp_hi_reg    <= bp[WIDTH-1:LO_W];
        lo_sum_reg   <= lo_sum_next;
        lo_carry_reg <= lo_carry_next;
      end
      if (s2_adv) begin
        s2_valid_reg <= s1_valid_reg;
      end
      if (s2_adv && s1_valid_reg) begin
        sum_reg   <= sum_next;
        flags_reg <= flags_next;
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign sum       = sum_reg;
  assign cout      = flags_reg[FLG_C];
  assign ovf       = flags_reg[FLG_V];
  assign zero      = flags_reg[FLG_Z];
  assign neg       = flags_reg[FLG_N];
endmodule

// File: tb/tb_add_sub_pipe.sv
// Self-checking bench for add_sub_pipe (WIDTH=16) against an arithmetic reference model.
module tb_add_sub_pipe;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic         sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         neg;

  int compared   = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c;
    logic         v;
    logic         z;
    logic         n;
  } exp_t;

  exp_t exp_q[$];

  add_sub_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in0       (in0),
    .in1       (in1),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero),
    .neg       (neg)
  );

  always #5 clk = ~clk;

  // Reference: true signed/unsigned arithmetic, then wrap or clamp.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   sa;
    int   sb;
    int   r;
    sa  = int'($signed(a));
    sb  = int'($signed(b));
    r   = s ? (sa - sb) : (sa + sb);
    e.v = (r > 32767) || (r < -32768);
    e.c = s ? (int'(a) >= int'(b)) : ((int'(a) + int'(b)) > 65535);
`ifdef ADD_SUB_SAT_EN
    if (e.v) e.sum = (r > 0) ? 16'h7FFF : 16'h8000;
    else     e.sum = 16'(r);
`else
    e.sum = 16'(r);
`endif
    e.z = (e.sum == 16'h0000);
    e.n = e.sum[W-1];
    return e;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("sum=%h c=%b v=%b z=%b n=%b", e.sum, e.c, e.v, e.z, e.n);
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.sum = sum;
    o.c   = cout;
    o.v   = ovf;
    o.z   = zero;
    o.n   = neg;
    return o;
  endfunction

  task automatic test_reset();
    exp_t zero_e;
    zero_e = '0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in0 = '0; in1 = '0; sel = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || observed() !== zero_e) begin
      mismatched++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b %s, expected in_ready=0 out_valid=0 %s",
               in_ready, out_valid, fmt(observed()), fmt(zero_e));
    end
    rst = 1'b0;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_ready: in_ready=%b, expected 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [8];
    logic [W-1:0] vb [8];
    logic         vs [8];
    exp_t e;
    va = '{16'h1975, 16'hF975, 16'h1975, 16'h0001, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
    vb = '{16'h0001, 16'hF001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0001};
    vs = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0,     1'b1,     1'b1,     1'b0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in0 = va[i]; in1 = vb[i]; sel = vs[i]; in_valid = 1'b1; out_ready = 1'b1;
      e = model(va[i], vb[i], vs[i]);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      compared++;
      if (out_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL dir%0d_early: out_valid=%b one cycle after accept, expected 0", i, out_valid);
      end
      @(negedge clk);
      #1;
      compared++;
      if (out_valid !== 1'b1 || observed() !== e) begin
        mismatched++;
        $display("FAIL dir%0d_result: out_valid=%b %s, expected out_valid=1 %s",
                 i, out_valid, fmt(observed()), fmt(e));
      end else begin
        $display("txn dir%0d: %h %s %h -> %s", i, va[i], vs[i] ? "-" : "+", vb[i], fmt(e));
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [W-1:0] corner [5];
    int   sent;
    int   got;
    int   c;
    logic pending;
    exp_t e;
    corner = '{16'h0000, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001};
    sent = 0; got = 0; c = 0; pending = 1'b0;
    while (got < n && c < 4000) begin
      @(negedge clk);
      if (!pending && sent < n && $urandom_range(3) != 0) begin
        in0 = ($urandom_range(3) == 0) ? corner[$urandom_range(4)] : 16'($urandom);
        in1 = ($urandom_range(3) == 0) ? corner[$urandom_range(4)] : 16'($urandom);
        sel = 1'($urandom_range(1));
        pending = 1'b1;
      end
      in_valid  = pending;
      out_ready = ($urandom_range(3) != 0);
      #1;
      if (out_valid && out_ready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL rnd_spurious: %s with no bundle outstanding, expected none", fmt(observed()));
        end else begin
          e = exp_q.pop_front();
          if (observed() !== e) begin
            mismatched++;
            $display("FAIL rnd_result%0d: %s, expected %s", got, fmt(observed()), fmt(e));
          end else begin
            $display("txn rnd%0d: %s", got, fmt(e));
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in0, in1, sel));
        sent++;
        pending = 1'b0;
      end
      c++;
    end
    in_valid = 1'b0;
    compared++;
    if (got != n || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL rnd_count: received %0d with %0d outstanding, expected %0d with 0", got, exp_q.size(), n);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int   sent;
    int   got;
    int   last_take;
    exp_t e;
    sent = 0; got = 0; last_take = -1;
    for (int c = 0; c < 30 && got < 6; c++) begin
      @(negedge clk);
      if (sent < 6) begin
        in0 = 16'(16'h3000 + 16'(c * 16'h0111));
        in1 = 16'(16'h0F00 + 16'(c));
        sel = 1'(c % 2);
      end
      in_valid  = (sent < 6);
      out_ready = !(c >= 2 && c < 5);
      #1;
      if (c >= 2 && c < 5) begin
        compared++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || exp_q.size() != 2) begin
          mismatched++;
          $display("FAIL b2b_full_c%0d: in_ready=%b out_valid=%b held=%0d, expected in_ready=0 out_valid=1 held=2",
                   c, in_ready, out_valid, exp_q.size());
        end
      end
      if (c == 5) begin
        compared++;
        if (in_ready !== 1'b1) begin
          mismatched++;
          $display("FAIL b2b_pass_through: in_ready=%b on full pipe with out_ready=1, expected 1", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL b2b_spurious: %s with none outstanding, expected none", fmt(observed()));
        end else begin
          e = exp_q.pop_front();
          if (observed() !== e) begin
            mismatched++;
            $display("FAIL b2b_result%0d: %s, expected %s", got, fmt(observed()), fmt(e));
          end else begin
            $display("txn b2b%0d: %s", got, fmt(e));
          end
        end
        got++;
        last_take = c;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in0, in1, sel));
        sent++;
      end
    end
    in_valid = 1'b0;
    compared++;
    if (got != 6 || last_take != 10 || exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL b2b_throughput: received %0d, last at cycle %0d, %0d outstanding; expected 6, cycle 10, 0",
               got, last_take, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_mid_reset();
    exp_t zero_e;
    exp_t e;
    zero_e = '0;
    @(negedge clk);
    in0 = 16'h1234; in1 = 16'h1111; sel = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in0 = 16'h4321; in1 = 16'h0101; sel = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL mrst_full: out_valid=%b in_ready=%b, expected out_valid=1 in_ready=0", out_valid, in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0 || observed() !== zero_e || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL mrst_cleared: out_valid=%b in_ready=%b %s, expected out_valid=0 in_ready=1 %s",
               out_valid, in_ready, fmt(observed()), fmt(zero_e));
    end
    out_ready = 1'b1;
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL mrst_dropped: out_valid=%b after reset with no new input, expected 0", out_valid);
    end
    in0 = 16'h5A5A; in1 = 16'h6B6B; sel = 1'b1; in_valid = 1'b1;
    e = model(16'h5A5A, 16'h6B6B, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    compared++;
    if (out_valid !== 1'b1 || observed() !== e) begin
      mismatched++;
      $display("FAIL mrst_new_op: out_valid=%b %s, expected out_valid=1 %s", out_valid, fmt(observed()), fmt(e));
    end else begin
      $display("txn mrst: 5a5a - 6b6b -> %s", fmt(e));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random(60);
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
